// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand selection.
// Registers decoded operands and controls from ID, resolves MEM/WB forwarding,
// drives the ALU operands and raises a load-use stall request.
module id_ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bubbleE,
  input  logic                  flushE,
  input  logic                  ValidD,
  input  logic [XLEN-1:0]       PCD,
  input  logic [XLEN-1:0]       RegOut1D,
  input  logic [XLEN-1:0]       RegOut2D,
  input  logic [XLEN-1:0]       ImmD,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic [3:0]            AluContrlD,
  input  logic                  AluSrc1D,
  input  logic [1:0]            AluSrc2D,
  input  logic                  RegWriteD,
  input  logic                  LoadD,
  input  logic                  StoreD,
  input  logic [XLEN-1:0]       AluOutM,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic                  RegWriteM,
  input  logic                  LoadM,
  input  logic [XLEN-1:0]       ResultW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteW,
  output logic [XLEN-1:0]       Operand1E,
  output logic [XLEN-1:0]       Operand2E,
  output logic [3:0]            AluContrlE,
  output logic [XLEN-1:0]       StoreDataE,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic                  RegWriteE,
  output logic                  LoadE,
  output logic                  StoreE,
  output logic                  ValidE,
  output logic [XLEN-1:0]       PCE,
  output logic                  LoadUseStallE
);

  // ALU op encodings shared with the ALU; ADD must stay 0 so a cleared stage is a NOP
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SLL = 4'd1;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SRA = 4'd6;

  logic [XLEN-1:0]       regOut1E;
  logic [XLEN-1:0]       regOut2E;
  logic [XLEN-1:0]       immE;
  logic [REG_ADDR_W-1:0] rs1E;
  logic [REG_ADDR_W-1:0] rs2E;
  logic                  aluSrc1E;
  logic [1:0]            aluSrc2E;
  logic [XLEN-1:0]       fwd1;
  logic [XLEN-1:0]       fwd2;
  logic [XLEN-1:0]       op2Raw;
  logic                  use1;
  logic                  use2;

  // Stage register: reset/flush clear to a NOP, bubble holds, otherwise capture ID
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      ValidE     <= 1'b0;
      PCE        <= '0;
      regOut1E   <= '0;
      regOut2E   <= '0;
      immE       <= '0;
      rs1E       <= '0;
      rs2E       <= '0;
      RdE        <= '0;
      AluContrlE <= ALU_ADD;
      aluSrc1E   <= 1'b0;
      aluSrc2E   <= 2'b00;
      RegWriteE  <= 1'b0;
      LoadE      <= 1'b0;
      StoreE     <= 1'b0;
    end else if (!bubbleE) begin
      ValidE     <= ValidD;
      PCE        <= PCD;
      regOut1E   <= RegOut1D;
      regOut2E   <= RegOut2D;
      immE       <= ImmD;
      rs1E       <= Rs1D;
      rs2E       <= Rs2D;
      RdE        <= RdD;
      AluContrlE <= AluContrlD;
      aluSrc1E   <= AluSrc1D;
      aluSrc2E   <= AluSrc2D;
      RegWriteE  <= RegWriteD & ValidD;
      LoadE      <= LoadD & ValidD;
      StoreE     <= StoreD & ValidD;
    end
  end

  // Forwarding: MEM (non-load) beats WB, and x0 is never forwarded
  always_comb begin
    fwd1 = regOut1E;
    fwd2 = regOut2E;
    if (RegWriteM && RdM != '0 && RdM == rs1E && !LoadM)
      fwd1 = AluOutM;
    else if (RegWriteW && RdW != '0 && RdW == rs1E)
      fwd1 = ResultW;
    if (RegWriteM && RdM != '0 && RdM == rs2E && !LoadM)
      fwd2 = AluOutM;
    else if (RegWriteW && RdW != '0 && RdW == rs2E)
      fwd2 = ResultW;
  end

  // Operand selection, with shift amounts trimmed to 5 bits for RV32 shifts
  always_comb begin
    Operand1E = aluSrc1E ? PCE : fwd1;
    op2Raw    = fwd2;
    case (aluSrc2E)
      2'b00:   op2Raw = fwd2;
      2'b01:   op2Raw = {{(XLEN-REG_ADDR_W){1'b0}}, rs2E};
      2'b10:   op2Raw = immE;
      default: op2Raw = XLEN'(4);
    endcase
    Operand2E = op2Raw;
    if (AluContrlE == ALU_SLL || AluContrlE == ALU_SRL || AluContrlE == ALU_SRA)
      Operand2E = {{(XLEN-5){1'b0}}, op2Raw[4:0]};
    StoreDataE = fwd2;
  end

  // Load-use detection: a load in MEM whose result this instruction actually reads
  always_comb begin
    use1 = (aluSrc1E == 1'b0);
    use2 = (aluSrc2E == 2'b00) || StoreE;
    LoadUseStallE = ValidE && RegWriteM && LoadM && (RdM != '0) &&
                    ((use1 && RdM == rs1E) || (use2 && RdM == rs2E));
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus
// randomized traffic compared against a behavioural model of the stage.
module tb_id_ex_operand_stage;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SLL = 4'd1;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;

  logic        clk = 1'b0;
  logic        rst, bubbleE, flushE, ValidD;
  logic [31:0] PCD, RegOut1D, RegOut2D, ImmD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [3:0]  AluContrlD;
  logic        AluSrc1D;
  logic [1:0]  AluSrc2D;
  logic        RegWriteD, LoadD, StoreD;
  logic [31:0] AluOutM;
  logic [4:0]  RdM;
  logic        RegWriteM, LoadM;
  logic [31:0] ResultW;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [31:0] Operand1E, Operand2E, StoreDataE, PCE;
  logic [3:0]  AluContrlE;
  logic [4:0]  RdE;
  logic        RegWriteE, LoadE, StoreE, ValidE, LoadUseStallE;

  int checkCount = 0;
  int passCount  = 0;

  // Instruction currently expected to sit in the E stage
  typedef struct {
    logic        valid;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        src1;
    logic [1:0]  src2;
    logic        rw, ld, st;
  } stage_t;

  stage_t model;

  id_ex_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .bubbleE(bubbleE), .flushE(flushE), .ValidD(ValidD),
    .PCD(PCD), .RegOut1D(RegOut1D), .RegOut2D(RegOut2D), .ImmD(ImmD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .AluContrlD(AluContrlD),
    .AluSrc1D(AluSrc1D), .AluSrc2D(AluSrc2D), .RegWriteD(RegWriteD),
    .LoadD(LoadD), .StoreD(StoreD), .AluOutM(AluOutM), .RdM(RdM),
    .RegWriteM(RegWriteM), .LoadM(LoadM), .ResultW(ResultW), .RdW(RdW),
    .RegWriteW(RegWriteW), .Operand1E(Operand1E), .Operand2E(Operand2E),
    .AluContrlE(AluContrlE), .StoreDataE(StoreDataE), .RdE(RdE),
    .RegWriteE(RegWriteE), .LoadE(LoadE), .StoreE(StoreE), .ValidE(ValidE),
    .PCE(PCE), .LoadUseStallE(LoadUseStallE)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
  endtask

  function automatic logic [31:0] expFwd(input logic [4:0] idx, input logic [31:0] regVal);
    if (RegWriteM && RdM != 0 && RdM == idx && !LoadM) return AluOutM;
    if (RegWriteW && RdW != 0 && RdW == idx) return ResultW;
    return regVal;
  endfunction

  function automatic logic [31:0] expOp1();
    return model.src1 ? model.pc : expFwd(model.rs1, model.r1);
  endfunction

  function automatic logic [31:0] expOp2();
    logic [31:0] v;
    case (model.src2)
      2'd0: v = expFwd(model.rs2, model.r2);
      2'd1: v = 32'(model.rs2);
      2'd2: v = model.imm;
      default: v = 32'd4;
    endcase
    if (model.op == OP_SLL || model.op == OP_SRL || model.op == OP_SRA) v = v % 32;
    return v;
  endfunction

  function automatic logic expStall();
    logic readsRs1, readsRs2;
    readsRs1 = !model.src1 && model.rs1 == RdM;
    readsRs2 = (model.src2 == 2'd0 || model.st) && model.rs2 == RdM;
    return model.valid && RegWriteM && LoadM && RdM != 0 && (readsRs1 || readsRs2);
  endfunction

  // Advance the model by one edge using the inputs the DUT is sampling
  task automatic tick();
    @(posedge clk);
    if (rst || flushE) begin
      model = '{valid: 0, pc: 0, r1: 0, r2: 0, imm: 0, rs1: 0, rs2: 0, rd: 0,
                op: OP_ADD, src1: 0, src2: 0, rw: 0, ld: 0, st: 0};
    end else if (!bubbleE) begin
      model = '{valid: ValidD, pc: PCD, r1: RegOut1D, r2: RegOut2D, imm: ImmD,
                rs1: Rs1D, rs2: Rs2D, rd: RdD, op: AluContrlD, src1: AluSrc1D,
                src2: AluSrc2D, rw: RegWriteD && ValidD, ld: LoadD && ValidD,
                st: StoreD && ValidD};
    end
    #1;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".valid"}, 32'(ValidE), 32'(model.valid));
    checkOutput({tag, ".rw"}, 32'(RegWriteE), 32'(model.rw));
    checkOutput({tag, ".ld"}, 32'(LoadE), 32'(model.ld));
    checkOutput({tag, ".st"}, 32'(StoreE), 32'(model.st));
    checkOutput({tag, ".rd"}, 32'(RdE), 32'(model.rd));
    checkOutput({tag, ".pc"}, PCE, model.pc);
    checkOutput({tag, ".op"}, 32'(AluContrlE), 32'(model.op));
    checkOutput({tag, ".op1"}, Operand1E, expOp1());
    checkOutput({tag, ".op2"}, Operand2E, expOp2());
    checkOutput({tag, ".sdata"}, StoreDataE, expFwd(model.rs2, model.r2));
    checkOutput({tag, ".stall"}, 32'(LoadUseStallE), 32'(expStall()));
  endtask

  task automatic clearMw();
    AluOutM = 0; RdM = 0; RegWriteM = 0; LoadM = 0;
    ResultW = 0; RdW = 0; RegWriteW = 0;
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] op, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] r1, input logic [31:0] r2,
                               input logic src1, input logic [1:0] src2);
    ValidD = valid; AluContrlD = op; Rs1D = rs1; Rs2D = rs2;
    RegOut1D = r1; RegOut2D = r2; AluSrc1D = src1; AluSrc2D = src2;
    RdD = 5'd3; RegWriteD = 1; LoadD = 0; StoreD = 0;
    PCD = $urandom(); ImmD = $urandom();
  endtask

  task automatic randomizeMw();
    AluOutM = $urandom(); RdM = 5'($urandom_range(0, 7));
    RegWriteM = 1'($urandom_range(0, 1)); LoadM = 1'($urandom_range(0, 1));
    ResultW = $urandom(); RdW = 5'($urandom_range(0, 7));
    RegWriteW = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1; bubbleE = 0; flushE = 0;
    clearMw();
    applyStimulus(1, OP_SLL, 5'd9, 5'd10, 32'hDEAD_BEEF, 32'h1234_5678, 1, 2'd3);
    RdD = 5'd17;

    // Reset with arbitrary D inputs
    tick(); tick();
    checkOutput("rst.valid", 32'(ValidE), 32'd0);
    checkOutput("rst.rw", 32'(RegWriteE), 32'd0);
    checkOutput("rst.rd", 32'(RdE), 32'd0);
    checkOutput("rst.pc", PCE, 32'd0);
    checkOutput("rst.op1", Operand1E, 32'd0);
    checkOutput("rst.op2", Operand2E, 32'd0);
    checkOutput("rst.stall", 32'(LoadUseStallE), 32'd0);
    checkOutput("rst.aluop", 32'(AluContrlE), 32'(OP_ADD));
    @(negedge clk);
    rst = 0;

    // MEM forwarding wins over WB on a double match
    applyStimulus(1, OP_ADD, 5'd5, 5'd6, 32'd1, 32'd2, 0, 2'd0);
    tick();
    RegWriteM = 1; RdM = 5'd5; AluOutM = 32'h100;
    RegWriteW = 1; RdW = 5'd5; ResultW = 32'h200;
    #1;
    checkOutput("memfwd.op1", Operand1E, 32'h100);
    checkOutput("memfwd.op2", Operand2E, 32'd2);
    checkAll("memfwd");

    // x0 never forwards; WB forwards into rs2
    @(negedge clk);
    clearMw();
    applyStimulus(1, OP_ADD, 5'd0, 5'd7, 32'd0, 32'd9, 0, 2'd0);
    tick();
    RegWriteM = 1; RdM = 5'd0; AluOutM = 32'hFFFF;
    RegWriteW = 1; RdW = 5'd7; ResultW = 32'h55;
    #1;
    checkOutput("x0.op1", Operand1E, 32'd0);
    checkOutput("wbfwd.op2", Operand2E, 32'h55);
    checkAll("x0wb");

    // Shift amount masking
    @(negedge clk);
    clearMw();
    applyStimulus(1, OP_SLL, 5'd1, 5'd6, 32'd7, 32'h0000_0123, 0, 2'd0);
    tick();
    checkOutput("shift.reg", Operand2E, 32'h3);
    checkOutput("shift.sdata", StoreDataE, 32'h123);
    @(negedge clk);
    applyStimulus(1, OP_SLL, 5'd1, 5'd31, 32'd7, 32'hFFFF_FFFF, 0, 2'd1);
    tick();
    checkOutput("shift.shamt", Operand2E, 32'd31);

    // Load-use stall, then bubble while the value arrives from WB
    @(negedge clk);
    applyStimulus(1, OP_ADD, 5'd8, 5'd2, 32'h11, 32'h22, 0, 2'd2);
    tick();
    RegWriteM = 1; LoadM = 1; RdM = 5'd8;
    #1;
    checkOutput("lu.stall", 32'(LoadUseStallE), 32'd1);
    @(negedge clk);
    bubbleE = 1;
    applyStimulus(1, OP_SRA, 5'd12, 5'd13, $urandom(), $urandom(), 1, 2'd3);
    tick();
    RegWriteM = 0; LoadM = 0; RdM = 0;
    RegWriteW = 1; RdW = 5'd8; ResultW = 32'hAB;
    #1;
    checkOutput("lu.hold.stall", 32'(LoadUseStallE), 32'd0);
    checkOutput("lu.hold.op1", Operand1E, 32'hAB);
    checkOutput("lu.hold.op", 32'(AluContrlE), 32'(OP_ADD));
    checkAll("luhold");

    // Reset while the stall is pending drops the request
    @(negedge clk);
    bubbleE = 0; clearMw();
    applyStimulus(1, OP_ADD, 5'd8, 5'd2, 32'h11, 32'h22, 0, 2'd0);
    tick();
    RegWriteM = 1; LoadM = 1; RdM = 5'd8;
    #1;
    checkOutput("rststall.pre", 32'(LoadUseStallE), 32'd1);
    @(negedge clk);
    rst = 1;
    tick();
    checkOutput("rststall.post", 32'(LoadUseStallE), 32'd0);
    @(negedge clk);
    rst = 0; clearMw();

    // Flush wins over bubble
    applyStimulus(1, OP_ADD, 5'd4, 5'd5, 32'h44, 32'h55, 0, 2'd0);
    tick();
    @(negedge clk);
    flushE = 1; bubbleE = 1;
    tick();
    checkOutput("flush.valid", 32'(ValidE), 32'd0);
    checkOutput("flush.rw", 32'(RegWriteE), 32'd0);
    @(negedge clk);
    flushE = 0; bubbleE = 0;

    // JAL-style PC + 4
    applyStimulus(1, OP_ADD, 5'd0, 5'd0, 32'd0, 32'd0, 1, 2'd3);
    PCD = 32'h1000;
    tick();
    checkOutput("jal.op1", Operand1E, 32'h1000);
    checkOutput("jal.op2", Operand2E, 32'd4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] opList [6];
      opList = '{OP_ADD, OP_SLL, OP_SRL, OP_SRA, 4'd2, 4'd3};
      @(negedge clk);
      rst     = ($urandom_range(0, 49) == 0);
      flushE  = ($urandom_range(0, 19) == 0);
      bubbleE = ($urandom_range(0, 4) == 0);
      ValidD  = ($urandom_range(0, 7) != 0);
      PCD = $urandom(); RegOut1D = $urandom(); RegOut2D = $urandom(); ImmD = $urandom();
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      RdD = 5'($urandom_range(0, 31));
      AluContrlD = opList[$urandom_range(0, 5)];
      AluSrc1D = 1'($urandom_range(0, 1)); AluSrc2D = 2'($urandom_range(0, 3));
      RegWriteD = 1'($urandom_range(0, 1)); LoadD = 1'($urandom_range(0, 1));
      StoreD = 1'($urandom_range(0, 1));
      randomizeMw();
      tick();
      randomizeMw();
      #1;
      checkAll("rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
